// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a small transmit FIFO.
// Frame on tx: start bit, data LSB first, optional parity, one or two stop bits.
// tx is registered from the FSM state, so the line trails the state by one cycle.
module uart_tx_param #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    input  logic [DATA_BITS-1:0]          s_data,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]       StopLast = 4'(STOP_BITS - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);
    localparam logic             OddPar   = (PARITY == 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                state_q, state_d;
    logic [BaudW-1:0]      baud_q, baud_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  s_ready_q;
    logic [CntW-1:0]       count_q, count_d;
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
    logic                  push, pop, baud_end;

    // s_ready is registered, so a full FIFO stays closed even during a pop cycle.
    assign push     = s_valid && s_ready_q;
    assign baud_end = (baud_q == BaudLast);

    // FSM next state, bit timing, line value and FIFO pop decision.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BaudW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                tx_d = shift_q[0];
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            StParity: begin
                tx_d = par_q;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == StopLast) begin
                        bit_d  = '0;
                        done_d = 1'b1;
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Load the head word and its parity as the frame starts.
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            par_d   = (^mem_q[rd_ptr_q]) ^ OddPar;
        end
    end

    // FIFO occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // State, pointers and registered outputs; reset discards any queued words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            s_ready_q <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            s_ready_q <= (count_d != CntFull);
            count_q   <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // FIFO storage; words are captured at push time.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    assign s_ready    = s_ready_q;
    assign tx         = tx_q;
    assign done       = done_q;
    assign fifo_count = count_q;
    // done_q marks the cycle the last stop bit is still on the line.
    assign busy       = (state_q != StIdle) || (count_q != '0) || done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: three configurations, scoreboard of expected frames.
module tb_uart_tx_param;

    localparam int CPB = 4;

    typedef struct packed {
        logic [15:0] bits;
        int          nbits;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    int         sel;

    logic       ready_e, tx_e, busy_e, done_e;
    logic       ready_o, tx_o, busy_o, done_o;
    logic       ready_n, tx_n, busy_n, done_n;
    logic [2:0] cnt_e, cnt_o, cnt_n;

    logic       tx_mon, done_mon, busy_mon, ready_mon;
    logic [2:0] count_mon;

    int         total = 0;
    int         bad   = 0;
    logic       last_busy;
    frame_t     exp_q[$];

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1),
                    .FIFO_DEPTH(4)) dut_e (
        .clk(clk), .rst(rst), .s_valid(s_valid && sel == 0), .s_data(s_data),
        .s_ready(ready_e), .tx(tx_e), .busy(busy_e), .done(done_e), .fifo_count(cnt_e));

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1),
                    .FIFO_DEPTH(4)) dut_o (
        .clk(clk), .rst(rst), .s_valid(s_valid && sel == 1), .s_data(s_data),
        .s_ready(ready_o), .tx(tx_o), .busy(busy_o), .done(done_o), .fifo_count(cnt_o));

    uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2),
                    .FIFO_DEPTH(4)) dut_n (
        .clk(clk), .rst(rst), .s_valid(s_valid && sel == 2), .s_data(s_data[6:0]),
        .s_ready(ready_n), .tx(tx_n), .busy(busy_n), .done(done_n), .fifo_count(cnt_n));

    assign tx_mon    = (sel == 0) ? tx_e    : (sel == 1) ? tx_o    : tx_n;
    assign done_mon  = (sel == 0) ? done_e  : (sel == 1) ? done_o  : done_n;
    assign busy_mon  = (sel == 0) ? busy_e  : (sel == 1) ? busy_o  : busy_n;
    assign ready_mon = (sel == 0) ? ready_e : (sel == 1) ? ready_o : ready_n;
    assign count_mon = (sel == 0) ? cnt_e   : (sel == 1) ? cnt_o   : cnt_n;

    // Reference frame: start 0, data LSB first, optional parity, stop bits of 1.
    function automatic frame_t make_frame(input logic [7:0] d, input int dbits, input int par,
                                          input int stops);
        frame_t f;
        int     n;
        logic   p;
        f.bits = '0;
        n      = 1;
        p      = 1'b0;
        for (int i = 0; i < dbits; i++) begin
            f.bits[n] = d[i];
            p         = p ^ d[i];
            n++;
        end
        if (par != 0) begin
            f.bits[n] = (par == 1) ? ~p : p;
            n++;
        end
        for (int i = 0; i < stops; i++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits = n;
        return f;
    endfunction

    function automatic frame_t frame_for_sel(input logic [7:0] d);
        case (sel)
            0:       return make_frame(d, 8, 2, 1);
            1:       return make_frame(d, 8, 1, 1);
            default: return make_frame(d, 7, 0, 2);
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_word(input logic [7:0] d);
        int n;
        s_data  = d;
        s_valid = 1'b1;
        n       = 0;
        while (ready_mon !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (ready_mon !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL push_ready_timeout got s_ready=%b want 1", ready_mon);
            s_valid = 1'b0;
            return;
        end
        exp_q.push_back(frame_for_sel(d));
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Waits for a start bit, then checks every cycle of the frame and the done pulse.
    task automatic rx_frame(input string name, input int exp_gap);
        frame_t      f;
        int          gap, bad_cyc, done_hits, done_at;
        logic [15:0] obs;
        gap = 0;
        while (tx_mon !== 1'b0 && gap < 3000) begin
            @(negedge clk);
            gap++;
        end
        total++;
        if (tx_mon !== 1'b0) begin
            bad++;
            $display("FAIL %s start_timeout got tx=%b want 0", name, tx_mon);
            return;
        end
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard_empty got a frame want none", name);
            return;
        end
        f = exp_q.pop_front();
        if (exp_gap >= 0) begin
            total++;
            if (gap !== exp_gap) begin
                bad++;
                $display("FAIL %s start_latency got=%0d want=%0d", name, gap, exp_gap);
            end
        end
        bad_cyc   = 0;
        done_hits = 0;
        done_at   = -1;
        obs       = '0;
        for (int i = 0; i < f.nbits * CPB; i++) begin
            if (tx_mon !== f.bits[i / CPB]) bad_cyc++;
            if (i % CPB == CPB / 2) obs[i / CPB] = tx_mon;
            if (done_mon === 1'b1) begin
                done_hits++;
                done_at = i;
            end
            if (i == f.nbits * CPB - 1) last_busy = busy_mon;
            @(negedge clk);
        end
        total++;
        if (bad_cyc != 0 || obs !== f.bits) begin
            bad++;
            $display("FAIL %s frame got=%b want=%b bad_cycles=%0d", name, obs, f.bits, bad_cyc);
        end
        total++;
        if (done_hits != 1 || done_at != f.nbits * CPB - 1) begin
            bad++;
            $display("FAIL %s done got hits=%0d at=%0d want hits=1 at=%0d", name, done_hits,
                     done_at, f.nbits * CPB - 1);
        end
    endtask

    task automatic test_reset();
        sel     = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(negedge clk);
        total++;
        if (tx_mon !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx_mon); end
        total++;
        if (done_mon !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_mon); end
        total++;
        if (busy_mon !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_mon); end
        total++;
        if (ready_mon !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b want=0", ready_mon);
        end
        total++;
        if (count_mon !== 3'd0) begin
            bad++; $display("FAIL reset_count got=%0d want=0", count_mon);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ready_mon !== 1'b1) begin
            bad++; $display("FAIL ready_after_reset got=%b want=1", ready_mon);
        end
    endtask

    task automatic test_even_parity();
        sel = 0;
        push_word(8'hA5);
        rx_frame("even_a5", 2);
        total++;
        if (tx_mon !== 1'b1 || busy_mon !== 1'b0) begin
            bad++; $display("FAIL even_idle_after got tx=%b busy=%b want tx=1 busy=0", tx_mon,
                            busy_mon);
        end
    endtask

    task automatic test_odd_parity();
        sel = 1;
        push_word(8'h00);
        rx_frame("odd_00", 2);
        push_word(8'h01);
        rx_frame("odd_01", 2);
    endtask

    task automatic test_two_stop();
        sel = 2;
        push_word(8'h7F);
        rx_frame("stop2_7f", 2);
        total++;
        if (tx_mon !== 1'b1 || busy_mon !== 1'b0) begin
            bad++; $display("FAIL stop2_idle_after got tx=%b busy=%b want tx=1 busy=0", tx_mon,
                            busy_mon);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [6];
        int         viol;
        int         saw_full;
        words    = '{8'h3A, 8'hC5, 8'h01, 8'hFE, 8'h80, 8'h7F};
        viol     = 0;
        saw_full = 0;
        sel      = 0;
        fork
            begin
                s_valid = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    int n;
                    s_data = words[k];
                    n      = 0;
                    while (1) begin
                        if (count_mon == 3'd4) saw_full = 1;
                        if (count_mon == 3'd4 && ready_mon !== 1'b0) viol++;
                        if (count_mon > 3'd4) viol++;
                        if (ready_mon === 1'b1 || n >= 300) break;
                        @(negedge clk);
                        n++;
                    end
                    exp_q.push_back(frame_for_sel(words[k]));
                    @(negedge clk);
                    // Scribble on s_data between pushes; queued words must be unaffected.
                    s_data = 8'h00;
                end
                s_valid = 1'b0;
            end
            begin
                rx_frame("b2b_0", -1);
                for (int k = 1; k < 6; k++) rx_frame("b2b_n", 0);
            end
        join
        total++;
        if (viol != 0 || saw_full != 1) begin
            bad++; $display("FAIL b2b_full_ready got viol=%0d saw_full=%0d want 0 and 1", viol,
                            saw_full);
        end
        total++;
        if (last_busy !== 1'b1 || busy_mon !== 1'b0) begin
            bad++; $display("FAIL b2b_busy_fall got done_cycle=%b after=%b want 1 then 0",
                            last_busy, busy_mon);
        end
    endtask

    task automatic test_push_pop();
        sel = 0;
        fork
            begin
                push_word(8'h11);
                push_word(8'h22);
                push_word(8'h33);
                total++;
                if (count_mon !== 3'd2) begin
                    bad++; $display("FAIL pp_count_before got=%0d want=2", count_mon);
                end
                repeat (42) @(negedge clk);
                s_data  = 8'h44;
                s_valid = 1'b1;
                exp_q.push_back(frame_for_sel(8'h44));
                @(negedge clk);
                s_valid = 1'b0;
                total++;
                if (count_mon !== 3'd2 || done_mon !== 1'b1) begin
                    bad++; $display("FAIL pp_count_same got count=%0d done=%b want 2 and 1",
                                    count_mon, done_mon);
                end
            end
            begin
                rx_frame("pp_0", -1);
                for (int k = 1; k < 4; k++) rx_frame("pp_n", 0);
            end
        join
    endtask

    task automatic test_reset_midframe();
        int n, d_hits, t_low, c_nz;
        sel = 0;
        push_word(8'h3C);
        push_word(8'h99);
        n = 0;
        while (tx_mon !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (tx_mon !== 1'b1 || count_mon !== 3'd0) begin
            bad++; $display("FAIL midrst_edge got tx=%b count=%0d want tx=1 count=0", tx_mon,
                            count_mon);
        end
        total++;
        if (busy_mon !== 1'b0 || done_mon !== 1'b0) begin
            bad++; $display("FAIL midrst_flags got busy=%b done=%b want 0 0", busy_mon, done_mon);
        end
        rst = 1'b0;
        exp_q.delete();
        d_hits = 0;
        t_low  = 0;
        c_nz   = 0;
        for (int i = 0; i < 60; i++) begin
            if (done_mon === 1'b1) d_hits++;
            if (tx_mon !== 1'b1) t_low++;
            if (count_mon !== 3'd0) c_nz++;
            @(negedge clk);
        end
        total++;
        if (d_hits != 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", d_hits); end
        total++;
        if (t_low != 0 || c_nz != 0) begin
            bad++; $display("FAIL midrst_quiet got tx_low=%0d count_nz=%0d want 0 0", t_low, c_nz);
        end
        push_word(8'h5A);
        rx_frame("midrst_new", 2);
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_two_stop();
        test_back_to_back();
        test_push_pop();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
